// File: rtl/keccak_globals_pkg.sv
// rtl/keccak_globals_pkg.sv - shared constants and FSM state type for the Keccak round controller
package keccak_globals;

  localparam int KECCAK_NUM_ROUNDS = 24;
  localparam int KECCAK_RND_W      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } keccak_ctrl_state_t;

endpackage

// File: rtl/keccak_round_counter.sv
// rtl/keccak_round_counter.sv - round index counter with clear, step and final-round flag
module keccak_round_counter
  import keccak_globals::*;
#(
  parameter int NUM_ROUNDS       = KECCAK_NUM_ROUNDS,
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int RND_W            = KECCAK_RND_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_step_en,
  input  logic [RND_W-1:0] i_step,
  output logic [RND_W-1:0] o_count,
  output logic             o_last
);

  localparam logic [RND_W-1:0] LAST_IDX = RND_W'(NUM_ROUNDS - ROUNDS_PER_CYCLE);

  logic [RND_W-1:0] r_count;

  // Clear wins over stepping so a fresh permutation always starts at round 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_step_en) begin
      r_count <= r_count + i_step;
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == LAST_IDX);

endmodule

// File: rtl/keccak_round_controller.sv
// rtl/keccak_round_controller.sv - IDLE/RUN/DONE sequencer for one Keccak-f[1600] permutation (optional abort: KECCAK_CTRL_ABORT_EN)
module keccak_round_controller
  import keccak_globals::*;
#(
  parameter int NUM_ROUNDS       = KECCAK_NUM_ROUNDS,
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int RND_W            = KECCAK_RND_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic             ready_o,
  output logic             state_load_o,
  output logic             state_en_o,
  output logic [RND_W-1:0] round_number_o,
  output logic             round_last_o,
  output logic             busy_o,
  output logic             done_o,
  input  logic             done_ready_i
`ifdef KECCAK_CTRL_ABORT_EN
  ,
  input  logic             abort_i
`endif
);

  generate
    if ((ROUNDS_PER_CYCLE < 1) || (NUM_ROUNDS % ROUNDS_PER_CYCLE != 0)) begin : g_bad_rpc
      $error("ROUNDS_PER_CYCLE must divide NUM_ROUNDS");
    end
    if (NUM_ROUNDS > (1 << RND_W)) begin : g_bad_rnd_w
      $error("NUM_ROUNDS does not fit in RND_W bits");
    end
  endgenerate

  keccak_ctrl_state_t r_state;
  keccak_ctrl_state_t w_state_nxt;

  logic             w_abort;
  logic             w_in_run;
  logic             w_in_done;
  logic             w_accept;
  logic             w_cnt_clear;
  logic             w_cnt_last;
  logic [RND_W-1:0] w_cnt;

`ifdef KECCAK_CTRL_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  assign w_in_run  = (r_state == RUN);
  assign w_in_done = (r_state == DONE);

  // A DONE cycle whose result is being consumed may accept the next request directly.
  assign ready_o   = (r_state == IDLE) | (w_in_done & done_ready_i);
  assign w_accept  = start_i & ready_o & ~w_abort;

  // Counter returns to 0 on load, on abort, and after the final round so IDLE/DONE see 0.
  assign w_cnt_clear = w_accept | w_abort | (w_in_run & w_cnt_last);

  keccak_round_counter #(
    .NUM_ROUNDS       (NUM_ROUNDS),
    .ROUNDS_PER_CYCLE (ROUNDS_PER_CYCLE),
    .RND_W            (RND_W)
  ) u_round_counter (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_cnt_clear),
    .i_step_en (w_in_run),
    .i_step    (RND_W'(ROUNDS_PER_CYCLE)),
    .o_count   (w_cnt),
    .o_last    (w_cnt_last)
  );

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_state_nxt = RUN;
        RUN:     if (w_cnt_last) w_state_nxt = DONE;
        DONE: begin
          if (w_accept)          w_state_nxt = RUN;
          else if (done_ready_i) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State register; reset discards any in-flight permutation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign state_load_o   = w_accept;
  assign state_en_o     = w_in_run & ~w_abort;
  assign round_number_o = w_in_run ? w_cnt : '0;
  assign round_last_o   = w_in_run & w_cnt_last;
  assign busy_o         = w_in_run;
  assign done_o         = w_in_done;

endmodule

// File: tb/tb_keccak_round_controller.sv
// tb/tb_keccak_round_controller.sv - directed scoreboard bench for keccak_round_controller
module tb_keccak_round_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic       done_ready;
  logic       abort;
  logic       sel;
  int         cyc;
  int         checks;
  int         fails;
  int         exp_q[$];

  logic       start1, ready1, load1, en1, last1, busy1, done1;
  logic [4:0] round1;
  logic       start2, ready2, load2, en2, last2, busy2, done2;
  logic [4:0] round2;

  logic       o_ready, o_load, o_en, o_last, o_busy, o_done;
  logic [4:0] o_round;

  assign start1 = start & ~sel;
  assign start2 = start & sel;

  keccak_round_controller #(.NUM_ROUNDS(24), .ROUNDS_PER_CYCLE(1), .RND_W(5)) u_dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .ready_o(ready1), .state_load_o(load1),
    .state_en_o(en1), .round_number_o(round1), .round_last_o(last1), .busy_o(busy1),
    .done_o(done1), .done_ready_i(done_ready)
`ifdef KECCAK_CTRL_ABORT_EN
    , .abort_i(abort & ~sel)
`endif
  );

  keccak_round_controller #(.NUM_ROUNDS(24), .ROUNDS_PER_CYCLE(2), .RND_W(5)) u_dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .ready_o(ready2), .state_load_o(load2),
    .state_en_o(en2), .round_number_o(round2), .round_last_o(last2), .busy_o(busy2),
    .done_o(done2), .done_ready_i(done_ready)
`ifdef KECCAK_CTRL_ABORT_EN
    , .abort_i(abort & sel)
`endif
  );

  always_comb begin
    o_ready = sel ? ready2 : ready1;
    o_load  = sel ? load2  : load1;
    o_en    = sel ? en2    : en1;
    o_last  = sel ? last2  : last1;
    o_busy  = sel ? busy2  : busy1;
    o_done  = sel ? done2  : done1;
    o_round = sel ? round2 : round1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, o_ready, 1);
    chk({tag, "_load"},  o_load,  0);
    chk({tag, "_en"},    o_en,    0);
    chk({tag, "_round"}, o_round, 0);
    chk({tag, "_last"},  o_last,  0);
    chk({tag, "_busy"},  o_busy,  0);
    chk({tag, "_done"},  o_done,  0);
  endtask

  // Called at posedge+1 of a cycle in which the DUT is ready; returns at posedge+1 of the DONE cycle.
  task automatic perm(input int rpc, input logic exp_done_at_start);
    int t0;
    int n;
    int e;
    start = 1'b1;
    @(negedge clk);
    chk("start_load", o_load, 1);
    chk("start_ready", o_ready, 1);
    chk("start_done", o_done, exp_done_at_start);
    chk("start_en", o_en, 0);
    t0 = cyc;
    for (int r = 0; r < 24; r += rpc) exp_q.push_back(r);
    next_cycle();
    start = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk("run_en", o_en, 1);
      chk("run_busy", o_busy, 1);
      chk("run_load", o_load, 0);
      chk("run_ready", o_ready, 0);
      chk("run_round", o_round, e);
      chk("run_last", o_last, (exp_q.size() == 0) ? 1 : 0);
      n++;
      next_cycle();
    end
    start = 1'b0;
    chk("done_latency", cyc, t0 + 1 + 24 / rpc);
  endtask

  // In a DONE cycle: consume the result and confirm the return to IDLE.
  task automatic drain();
    start = 1'b0;
    done_ready = 1'b1;
    @(negedge clk);
    chk("drain_done", o_done, 1);
    chk("drain_en", o_en, 0);
    chk("drain_round", o_round, 0);
    chk("drain_ready", o_ready, 1);
    chk("drain_busy", o_busy, 0);
    next_cycle();
    @(negedge clk);
    chk("idle_done", o_done, 0);
    chk("idle_ready", o_ready, 1);
    next_cycle();
  endtask

  initial begin
    int saw_done;
    checks = 0;
    fails = 0;
    cyc = 0;
    rst = 1'b0;
    start = 1'b0;
    done_ready = 1'b1;
    abort = 1'b0;
    sel = 1'b0;

    #2 rst = 1'b1;
    #1 chk_reset_outputs("por");
    repeat (3) next_cycle();
    rst = 1'b0;
    next_cycle();

    // Single 24-round permutation, immediate result consumption.
    perm(1, 0);
    drain();

    // Consumer stalls for 10 cycles; start requests are ignored meanwhile.
    done_ready = 1'b0;
    perm(1, 0);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_done", o_done, 1);
      chk("stall_round", o_round, 0);
      chk("stall_en", o_en, 0);
      chk("stall_load", o_load, 0);
      chk("stall_ready", o_ready, 0);
      next_cycle();
    end
    drain();

    // Back-to-back: the second start is accepted in the DONE cycle itself.
    done_ready = 1'b1;
    perm(1, 0);
    perm(1, 1);
    drain();

    // Two rounds per cycle.
    sel = 1'b1;
    perm(2, 0);
    drain();
    sel = 1'b0;

    // Asynchronous reset in the middle of round 7.
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (7) next_cycle();
    @(negedge clk);
    chk("pre_reset_round", o_round, 7);
    rst = 1'b1;
    #1 chk_reset_outputs("mid_rst");
    next_cycle();
    rst = 1'b0;
    exp_q.delete();
    perm(1, 0);
    drain();

`ifdef KECCAK_CTRL_ABORT_EN
    // Abort at round 12 with a simultaneous start request.
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (12) next_cycle();
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("abort_round", o_round, 12);
    chk("abort_load", o_load, 0);
    chk("abort_en", o_en, 0);
    next_cycle();
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk_reset_outputs("post_abort");
    saw_done = 0;
    for (int i = 0; i < 30; i++) begin
      next_cycle();
      @(negedge clk);
      if (o_done === 1'b1) saw_done = 1;
    end
    chk("abort_no_done", saw_done, 0);
    next_cycle();
`endif
    saw_done = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
